spi_xfer_ctrl: RTL

SPI master transfer sequencer for the shared `spi_common` shift datapath. It accepts transfer commands, drives SCLK and the chip selects, and paces the byte-load handshake toward `spi_tx`. It emits per-edge shift and sample strobes to `spi_tx` and `spi_rx`. It sits between the register/DMA front end and the shift engines and holds no data itself.

---
 rtl/spi_xfer_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: drives SCLK / chip selects, paces byte loads
// toward spi_tx and emits per-edge shift/sample strobes. Holds no data.
module spi_xfer_ctrl #(
  parameter int NCS   = 4,
  parameter int DIV_W = 8,
  parameter int LEN_W = 8,
  localparam int CS_W = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_cpol,
  input  logic             cfg_cpha,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [CS_W-1:0]  cmd_cs,
  input  logic             abort,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             shift_en,
  output logic             sample_en,
  output logic             byte_done,
  output logic             sclk,
  output logic [NCS-1:0]   cs_n,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, XFER, CS_HOLD} state_t;

  state_t state, nxt;

  // Per-transfer configuration captured at command accept
  logic             cpol_q, cpha_q, ab_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] rem_q;
  logic [CS_W-1:0]  cs_q;

  // Timing: half-period counter, bit counter, leading/trailing phase
  logic [DIV_W-1:0] hc;
  logic [2:0]       bc;
  logic             ph;

  logic             accept, abt, edg, last_edge;
  logic             eff_cpol;
  logic [CS_W-1:0]  eff_cs;

  logic             sclk_n, shift_n, sample_n, bd_n, done_n, aborted_n;
  logic [NCS-1:0]   cs_n_n;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_ready && cmd_valid;
  // abort in CS_HOLD is ignored so the hold time is never restarted
  assign abt       = abort && (state == CS_SETUP || state == LOAD || state == XFER);
  assign edg       = (state == XFER) && (hc == div_q);
  assign last_edge = edg && ph && (bc == 3'd7);
  // During the accept cycle the latched copies are not loaded yet
  assign eff_cpol  = (state == IDLE) ? cfg_cpol : cpol_q;
  assign eff_cs    = (state == IDLE) ? cmd_cs : cs_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    nxt       = state;
    sclk_n    = eff_cpol;
    shift_n   = 1'b0;
    sample_n  = 1'b0;
    bd_n      = 1'b0;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    cs_n_n    = '1;

    case (state)
      IDLE:     if (cmd_valid)      nxt = CS_SETUP;
      CS_SETUP: if (hc == div_q)    nxt = LOAD;
      LOAD:     if (tx_valid)       nxt = XFER;
      XFER:     if (last_edge)      nxt = (rem_q == '0) ? CS_HOLD : LOAD;
      CS_HOLD:  if (hc == div_q)    nxt = IDLE;
      default:                      nxt = IDLE;
    endcase
    if (abt) nxt = CS_HOLD;

    if (edg && !abt) begin
      if (!ph) begin
        // leading edge
        sample_n = !cpha_q;
        shift_n  = cpha_q && (bc != 3'd0);
      end else begin
        // trailing edge
        sample_n = cpha_q;
        shift_n  = !cpha_q && (bc != 3'd7);
        bd_n     = (bc == 3'd7);
      end
    end

    if (nxt == IDLE)              sclk_n = cfg_cpol;
    else if (edg && !abt)         sclk_n = ~sclk;
    else if (state == XFER && !abt) sclk_n = sclk;

    for (int i = 0; i < NCS; i++)
      cs_n_n[i] = !((nxt != IDLE) && (int'(eff_cs) == i));

    done_n    = (state == CS_HOLD) && (nxt == IDLE);
    aborted_n = done_n && ab_q;
  end

  // Command latch and transfer counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      div_q  <= '0;
      rem_q  <= '0;
      cs_q   <= '0;
      ab_q   <= 1'b0;
      hc     <= '0;
      bc     <= '0;
      ph     <= 1'b0;
    end else if (accept) begin
      cpol_q <= cfg_cpol;
      cpha_q <= cfg_cpha;
      div_q  <= cfg_div;
      rem_q  <= cmd_len;
      cs_q   <= cmd_cs;
      ab_q   <= 1'b0;
      hc     <= '0;
      bc     <= '0;
      ph     <= 1'b0;
    end else begin
      if (abt) ab_q <= 1'b1;
      if (nxt != state || hc == div_q)             hc <= '0;
      else if (state != IDLE && state != LOAD)     hc <= hc + DIV_W'(1);
      if (edg && !abt) begin
        ph <= ~ph;
        if (ph) bc <= bc + 3'd1;
      end
      if (last_edge && !abt && rem_q != '0) rem_q <= rem_q - LEN_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk      <= 1'b0;
      cs_n      <= '1;
      tx_ready  <= 1'b0;
      shift_en  <= 1'b0;
      sample_en <= 1'b0;
      byte_done <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      sclk      <= sclk_n;
      cs_n      <= cs_n_n;
      tx_ready  <= (nxt == LOAD);
      shift_en  <= shift_n;
      sample_en <= sample_n;
      byte_done <= bd_n;
      busy      <= (nxt != IDLE);
      done      <= done_n;
      aborted   <= aborted_n;
    end
  end

endmodule
